mem_arbiter: RTL and testbench

//  Shares the single multicycle-CPU memory port between two requesters: the CPU
//  (control-unit-driven fetch/load/store) and a debug/program loader (dbg).

---
 rtl/mem_arbiter.sv | 133 +++++++++++++
 tb/tb_mem_arbiter.sv | 469 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one fixed-latency memory port between CPU and
// debug loader; one transaction in flight, acks pulsed to the grantee.
//
// Ports:
//   clk, reset(active-low async)
//   cpu_req/we/addr/wdata -> cpu_ack    : CPU requester
//   dbg_req/we/addr/wdata -> dbg_ack    : debug/loader requester
//   rdata, busy, owner                  : status / last read data
//   mem_en/we/addr/wdata, mem_rdata     : unified memory port
module mem_arbiter #(
    parameter int AW      = 8,
    parameter int DW      = 16,
    parameter int MEM_LAT = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic          dbg_ack,
    output logic [DW-1:0] rdata,
    output logic          busy,
    output logic          owner,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        ACK
    } state_t;

    localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic          last_grant;
    logic          txn_we;
    logic [AW-1:0] txn_addr;
    logic [DW-1:0] txn_wdata;
    logic          grant_cpu;
    logic          grant_dbg;
    logic          wait_done;

    // CPU wins unless dbg also asks and the CPU was the last grantee.
    assign grant_cpu = cpu_req & (~dbg_req | last_grant);
    assign grant_dbg = dbg_req & ~grant_cpu;
    assign wait_done = (cnt == CW'(MEM_LAT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (grant_cpu | grant_dbg) state_nxt = ISSUE;
            ISSUE:   state_nxt = txn_we ? ACK : WAIT;
            WAIT:    if (wait_done) state_nxt = ACK;
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != IDLE);
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        cpu_ack   = 1'b0;
        dbg_ack   = 1'b0;
        unique case (state)
            ISSUE: begin
                mem_en    = 1'b1;
                mem_we    = txn_we;
                mem_addr  = txn_addr;
                mem_wdata = txn_wdata;
            end
            ACK: begin
                cpu_ack = ~owner;
                dbg_ack = owner;
            end
            default: ;
        endcase
    end

    // Transaction latch, grant history, latency counter and read capture.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt        <= '0;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            txn_we     <= 1'b0;
            txn_addr   <= '0;
            txn_wdata  <= '0;
            rdata      <= '0;
        end else begin
            if (state == IDLE && (grant_cpu | grant_dbg)) begin
                owner      <= grant_dbg;
                last_grant <= grant_dbg;
                txn_we     <= grant_dbg ? dbg_we : cpu_we;
                txn_addr   <= grant_dbg ? dbg_addr : cpu_addr;
                txn_wdata  <= grant_dbg ? dbg_wdata : cpu_wdata;
            end
            if (state == ISSUE) begin
                cnt <= '0;
            end else if (state == WAIT) begin
                cnt <= cnt + CW'(1);
            end
            if (state == WAIT && wait_done) begin
                rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scenario bench for mem_arbiter with a fixed-latency memory model and an
// expected-ack scoreboard.
module tb_mem_arbiter;

    localparam int AW  = 8;
    localparam int DW  = 16;
    localparam int LAT = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cpu_req = 1'b0;
    logic          cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic          cpu_ack;
    logic          dbg_req = 1'b0;
    logic          dbg_we = 1'b0;
    logic [AW-1:0] dbg_addr = '0;
    logic [DW-1:0] dbg_wdata = '0;
    logic          dbg_ack;
    logic [DW-1:0] rdata;
    logic          busy;
    logic          owner;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    mem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(LAT)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack),
        .dbg_req(dbg_req), .dbg_we(dbg_we),
        .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_ack(dbg_ack),
        .rdata(rdata), .busy(busy), .owner(owner),
        .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory model: read data is valid only in cycle ISSUE+LAT.
    logic [DW-1:0] mem [256];
    logic [LAT-1:0] pv = '0;
    logic [DW-1:0] pd [LAT];

    always @(posedge clk) begin
        if (mem_en && mem_we) mem[mem_addr] = mem_wdata;
        pv[0] <= mem_en && !mem_we;
        pd[0] <= mem[mem_addr];
        for (int i = 1; i < LAT; i++) begin
            pv[i] <= pv[i-1];
            pd[i] <= pd[i-1];
        end
    end

    assign mem_rdata = pv[LAT-1] ? pd[LAT-1] : 16'hDEAD;

    typedef struct packed {
        logic          who;
        logic [DW-1:0] rdata;
    } txn_t;

    txn_t          exp_q [$];
    logic [DW-1:0] shadow [256];
    logic [DW-1:0] last_rd = '0;
    int            checks = 0;
    int            errors = 0;

    logic          s_cpu_ack, s_dbg_ack, s_busy, s_owner;
    logic          s_mem_en, s_mem_we;
    logic [AW-1:0] s_mem_addr;
    logic [DW-1:0] s_mem_wdata, s_rdata;

    task automatic step();
        @(negedge clk);
        s_cpu_ack   = cpu_ack;
        s_dbg_ack   = dbg_ack;
        s_busy      = busy;
        s_owner     = owner;
        s_mem_en    = mem_en;
        s_mem_we    = mem_we;
        s_mem_addr  = mem_addr;
        s_mem_wdata = mem_wdata;
        s_rdata     = rdata;
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic who, input logic we,
                            input logic [AW-1:0] a,
                            input logic [DW-1:0] d);
        txn_t t;
        t.who = who;
        if (we) begin
            shadow[a] = d;
            t.rdata = last_rd;
        end else begin
            t.rdata = shadow[a];
            last_rd = shadow[a];
        end
        exp_q.push_back(t);
    endtask

    task automatic test_reset_state();
        #2 reset = 1'b0;
        #3;
        checks++;
        if ({cpu_ack, dbg_ack, busy, owner, mem_en, mem_we} !== 6'b0 ||
            mem_addr !== '0 || mem_wdata !== '0 || rdata !== '0) begin
            errors++;
            $display("FAIL reset_state: ack=%b%b busy=%b owner=%b en=%b rdata=%h, required all 0",
                     cpu_ack, dbg_ack, busy, owner, mem_en, rdata);
        end
        @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic test_cpu_read();
        txn_t e;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h12;
        push_exp(1'b0, 1'b0, 8'h12, '0);
        for (int c = 0; c < 7; c++) begin
            step();
            checks++;
            if (s_mem_en !== (c == 1)) begin
                errors++;
                $display("FAIL rd_mem_en c%0d: got %b required %b", c, s_mem_en, c == 1);
            end
            if (c == 1) begin
                checks++;
                if (s_mem_addr !== 8'h12 || s_mem_we !== 1'b0) begin
                    errors++;
                    $display("FAIL rd_issue: addr=%h we=%b required addr=12 we=0", s_mem_addr, s_mem_we);
                end
            end
            checks++;
            if (s_cpu_ack !== (c == LAT + 2) || s_dbg_ack !== 1'b0) begin
                errors++;
                $display("FAIL rd_ack c%0d: cpu=%b dbg=%b required cpu=%b dbg=0", c, s_cpu_ack, s_dbg_ack, c == LAT + 2);
            end
            if (s_cpu_ack || s_dbg_ack) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rd_stray_ack: got ack, required none");
                end else begin
                    e = exp_q.pop_front();
                    if (s_rdata !== e.rdata || s_owner !== e.who) begin
                        errors++;
                        $display("FAIL rd_data: rdata=%h owner=%b required %h %b", s_rdata, s_owner, e.rdata, e.who);
                    end
                end
                cpu_req = 1'b0;
            end
        end
    endtask

    task automatic test_dbg_write();
        txn_t e;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 8'h05; dbg_wdata = 16'h1234;
        push_exp(1'b1, 1'b1, 8'h05, 16'h1234);
        for (int c = 0; c < 5; c++) begin
            step();
            checks++;
            if (s_mem_en !== (c == 1)) begin
                errors++;
                $display("FAIL wr_mem_en c%0d: got %b required %b", c, s_mem_en, c == 1);
            end
            if (c == 1) begin
                checks++;
                if (s_mem_we !== 1'b1 || s_mem_addr !== 8'h05 || s_mem_wdata !== 16'h1234) begin
                    errors++;
                    $display("FAIL wr_issue: we=%b addr=%h wdata=%h required 1 05 1234", s_mem_we, s_mem_addr, s_mem_wdata);
                end
            end
            checks++;
            if (s_dbg_ack !== (c == 2) || s_cpu_ack !== 1'b0 || s_rdata !== 16'hBEEF) begin
                errors++;
                $display("FAIL wr_ack c%0d: dbg=%b cpu=%b rdata=%h required dbg=%b cpu=0 rdata=beef",
                         c, s_dbg_ack, s_cpu_ack, s_rdata, c == 2);
            end
            if (s_cpu_ack || s_dbg_ack) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL wr_stray_ack: got ack, required none");
                end else begin
                    e = exp_q.pop_front();
                    if (s_rdata !== e.rdata || s_owner !== e.who) begin
                        errors++;
                        $display("FAIL wr_data: rdata=%h owner=%b required %h %b", s_rdata, s_owner, e.rdata, e.who);
                    end
                end
                dbg_req = 1'b0;
            end
        end
    endtask

    task automatic test_async_reset();
        txn_t e;
        int acks = 0;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 8'h20;
        step();
        #2;
        checks++;
        if (busy !== 1'b1 || mem_en !== 1'b1 || owner !== 1'b1) begin
            errors++;
            $display("FAIL ar_pre: busy=%b en=%b owner=%b required 1 1 1", busy, mem_en, owner);
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({cpu_ack, dbg_ack, busy, owner, mem_en, mem_we} !== 6'b0 ||
            mem_addr !== '0 || mem_wdata !== '0 || rdata !== '0) begin
            errors++;
            $display("FAIL ar_outputs: ack=%b%b busy=%b owner=%b en=%b addr=%h rdata=%h, required all 0",
                     cpu_ack, dbg_ack, busy, owner, mem_en, mem_addr, rdata);
        end
        dbg_req = 1'b0;
        last_rd = '0;
        @(posedge clk);
        #1 reset = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h30;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 8'h31; dbg_wdata = 16'h5A5A;
        push_exp(1'b0, 1'b0, 8'h30, '0);
        push_exp(1'b1, 1'b1, 8'h31, 16'h5A5A);
        for (int c = 0; c < 20 && acks < 2; c++) begin
            step();
            if (s_cpu_ack || s_dbg_ack) begin
                acks++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL tie_stray_ack: got ack, required none");
                end else begin
                    e = exp_q.pop_front();
                    if ({s_cpu_ack, s_dbg_ack} !== {~e.who, e.who} ||
                        s_rdata !== e.rdata || s_owner !== e.who) begin
                        errors++;
                        $display("FAIL tie_order: ack=%b%b owner=%b rdata=%h required owner=%b rdata=%h",
                                 s_cpu_ack, s_dbg_ack, s_owner, s_rdata, e.who, e.rdata);
                    end
                end
                if (s_cpu_ack) cpu_req = 1'b0;
                if (s_dbg_ack) dbg_req = 1'b0;
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL tie_timeout: %0d acks outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_round_robin();
        txn_t e;
        int acks = 0;
        int ncpu = 0;
        int ndbg = 0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h40;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 8'h50; dbg_wdata = 16'hD000;
        push_exp(1'b0, 1'b0, 8'h40, '0);
        push_exp(1'b1, 1'b1, 8'h50, 16'hD000);
        push_exp(1'b0, 1'b0, 8'h41, '0);
        push_exp(1'b1, 1'b1, 8'h51, 16'hD001);
        for (int c = 0; c < 40 && acks < 4; c++) begin
            step();
            if (s_cpu_ack || s_dbg_ack) begin
                acks++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rr_stray_ack: got ack, required none");
                end else begin
                    e = exp_q.pop_front();
                    if ({s_cpu_ack, s_dbg_ack} !== {~e.who, e.who} ||
                        s_rdata !== e.rdata || s_owner !== e.who) begin
                        errors++;
                        $display("FAIL rr_order ack%0d: ack=%b%b owner=%b rdata=%h required owner=%b rdata=%h",
                                 acks, s_cpu_ack, s_dbg_ack, s_owner, s_rdata, e.who, e.rdata);
                    end
                end
                if (s_cpu_ack) begin
                    ncpu++;
                    cpu_addr = 8'h40 + 8'(ncpu);
                end
                if (s_dbg_ack) begin
                    ndbg++;
                    dbg_addr = 8'h50 + 8'(ndbg);
                    dbg_wdata = 16'hD000 + 16'(ndbg);
                end
            end
        end
        cpu_req = 1'b0;
        dbg_req = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL rr_timeout: %0d acks outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
        step();
        step();
        checks++;
        if (s_busy !== 1'b0) begin
            errors++;
            $display("FAIL rr_extra_grant: busy=%b required 0", s_busy);
        end
    endtask

    task automatic test_reset_in_wait();
        txn_t e;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h12;
        step();
        step();
        #2;
        checks++;
        if (busy !== 1'b1 || mem_en !== 1'b0) begin
            errors++;
            $display("FAIL rw_pre: busy=%b en=%b required 1 0", busy, mem_en);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || mem_en !== 1'b0 || cpu_ack !== 1'b0 || dbg_ack !== 1'b0) begin
            errors++;
            $display("FAIL rw_drop: busy=%b en=%b ack=%b%b required 0", busy, mem_en, cpu_ack, dbg_ack);
        end
        cpu_req = 1'b0;
        last_rd = '0;
        @(posedge clk);
        #1 reset = 1'b1;
        for (int c = 0; c < 6; c++) begin
            step();
            checks++;
            if (s_cpu_ack !== 1'b0 || s_dbg_ack !== 1'b0 || s_busy !== 1'b0) begin
                errors++;
                $display("FAIL rw_ghost c%0d: ack=%b%b busy=%b required 0", c, s_cpu_ack, s_dbg_ack, s_busy);
            end
        end
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 8'h13;
        push_exp(1'b1, 1'b0, 8'h13, '0);
        for (int c = 0; c < 7; c++) begin
            step();
            checks++;
            if (s_dbg_ack !== (c == LAT + 2) || s_cpu_ack !== 1'b0) begin
                errors++;
                $display("FAIL rw_lat c%0d: dbg=%b cpu=%b required dbg=%b cpu=0", c, s_dbg_ack, s_cpu_ack, c == LAT + 2);
            end
            if (s_cpu_ack || s_dbg_ack) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rw_stray_ack: got ack, required none");
                end else begin
                    e = exp_q.pop_front();
                    if (s_rdata !== e.rdata || s_owner !== e.who) begin
                        errors++;
                        $display("FAIL rw_data: rdata=%h owner=%b required %h %b", s_rdata, s_owner, e.rdata, e.who);
                    end
                end
                dbg_req = 1'b0;
            end
        end
    endtask

    task automatic test_back_to_back();
        txn_t e;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h60; cpu_wdata = 16'h1111;
        push_exp(1'b0, 1'b1, 8'h60, 16'h1111);
        step();
        cpu_req = 1'b0;
        for (int c = 1; c < 4; c++) begin
            step();
            checks++;
            if (s_cpu_ack !== (c == 2)) begin
                errors++;
                $display("FAIL drop_ack c%0d: cpu=%b required %b", c, s_cpu_ack, c == 2);
            end
            if (s_cpu_ack) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL drop_stray_ack: got ack, required none");
                end else begin
                    e = exp_q.pop_front();
                    if (s_rdata !== e.rdata || s_owner !== e.who) begin
                        errors++;
                        $display("FAIL drop_data: rdata=%h owner=%b required %h %b", s_rdata, s_owner, e.rdata, e.who);
                    end
                end
            end
        end
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 8'h12;
        push_exp(1'b1, 1'b0, 8'h12, '0);
        push_exp(1'b1, 1'b1, 8'h61, 16'h2222);
        for (int c = 0; c < 10; c++) begin
            step();
            checks++;
            if (s_dbg_ack !== (c == 4 || c == 7) || s_cpu_ack !== 1'b0) begin
                errors++;
                $display("FAIL b2b_ack c%0d: dbg=%b cpu=%b required dbg=%b cpu=0",
                         c, s_dbg_ack, s_cpu_ack, c == 4 || c == 7);
            end
            if (c == 5) begin
                checks++;
                if (s_busy !== 1'b0 || s_owner !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_idle: busy=%b owner=%b required 0 1", s_busy, s_owner);
                end
            end
            if (c == 6) begin
                checks++;
                if (s_mem_en !== 1'b1 || s_mem_we !== 1'b1 ||
                    s_mem_addr !== 8'h61 || s_mem_wdata !== 16'h2222) begin
                    errors++;
                    $display("FAIL b2b_issue: en=%b we=%b addr=%h wdata=%h required 1 1 61 2222",
                             s_mem_en, s_mem_we, s_mem_addr, s_mem_wdata);
                end
            end
            if (s_cpu_ack || s_dbg_ack) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_stray_ack: got ack, required none");
                end else begin
                    e = exp_q.pop_front();
                    if (s_rdata !== e.rdata || s_owner !== e.who) begin
                        errors++;
                        $display("FAIL b2b_data: rdata=%h owner=%b required %h %b", s_rdata, s_owner, e.rdata, e.who);
                    end
                end
                if (exp_q.size() == 0) begin
                    dbg_req = 1'b0;
                end else begin
                    dbg_we = 1'b1; dbg_addr = 8'h61; dbg_wdata = 16'h2222;
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]    = {~8'(i), 8'(i)};
            shadow[i] = {~8'(i), 8'(i)};
        end
        mem[8'h12]    = 16'hBEEF;
        shadow[8'h12] = 16'hBEEF;
        for (int i = 0; i < LAT; i++) pd[i] = '0;

        test_reset_state();
        test_cpu_read();
        test_dbg_write();
        test_async_reset();
        test_round_robin();
        test_reset_in_wait();
        test_back_to_back();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
